// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: op encoding, ALU control field
// values and the issue FSM state type.
// Optional feature macro used elsewhere in this slice: ALU_OVF_TRAP_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLT = 4'd2,
    ALU_LUI = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOR = 4'd7
  } alu_op_e;

  // FnClass values
  localparam logic [1:0] FC_LUI   = 2'b00;
  localparam logic [1:0] FC_SLT   = 2'b01;
  localparam logic [1:0] FC_ARITH = 2'b10;
  localparam logic [1:0] FC_LOGIC = 2'b11;

  // LogicFn values
  localparam logic [1:0] LF_AND = 2'b00;
  localparam logic [1:0] LF_OR  = 2'b01;
  localparam logic [1:0] LF_XOR = 2'b10;
  localparam logic [1:0] LF_NOR = 2'b11;

  // TRAP is only reachable when ALU_OVF_TRAP_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2,
    ST_TRAP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: maps the 4-bit op onto the ALU control fields.
// Unused fields are 0; illegal ops (8-15) give all controls 0.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output logic       add_sub,
  output logic [1:0] logic_fn,
  output logic [1:0] fn_class,
  output logic       illegal,
  output logic       ovf_mask
);

  // Translate op into ALU controls; ovf_mask marks ops whose overflow is meaningful.
  always_comb begin
    add_sub  = 1'b0;
    logic_fn = LF_AND;
    fn_class = FC_LUI;
    illegal  = 1'b0;
    ovf_mask = 1'b0;
    case (op)
      ALU_ADD: begin fn_class = FC_ARITH; ovf_mask = 1'b1; end
      ALU_SUB: begin add_sub = 1'b1; fn_class = FC_ARITH; ovf_mask = 1'b1; end
      ALU_SLT: begin add_sub = 1'b1; fn_class = FC_SLT; end
      ALU_LUI: fn_class = FC_LUI;
      ALU_AND: begin fn_class = FC_LOGIC; logic_fn = LF_AND; end
      ALU_OR:  begin fn_class = FC_LOGIC; logic_fn = LF_OR;  end
      ALU_XOR: begin fn_class = FC_LOGIC; logic_fn = LF_XOR; end
      ALU_NOR: begin fn_class = FC_LOGIC; logic_fn = LF_NOR; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the combinational ALU. Accepts one op per
// handshake, holds operands/controls for ALU_LAT cycles, captures the result
// and presents it on a valid/ready result channel.
// Optional feature: ALU_OVF_TRAP_EN adds a TRAP state (ovf_trap/trap_clr ports)
// entered after an overflowing result is consumed.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// EXEC  | controls held, down-counter runs to 0, result captured on the last cycle
// RESP  | out_valid=1, holding result until out_ready
// TRAP  | overflow trap raised, waiting for trap_clr (ALU_OVF_TRAP_EN only)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_add_sub,
  output logic [1:0]       alu_logic_fn,
  output logic [1:0]       alu_fn_class,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
`ifdef ALU_OVF_TRAP_EN
  output logic             ovf_trap,
  input  logic             trap_clr,
`endif
  output logic             out_illegal
);

  // Counter loads ALU_LAT-1 and terminates at 0, so it only spans 0..ALU_LAT-1.
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_e     state;
  logic [3:0] cnt;
  logic       illegal_q;
  logic       ovf_en;

  logic       dec_add_sub;
  logic [1:0] dec_logic_fn;
  logic [1:0] dec_fn_class;
  logic       dec_illegal;
  logic       dec_ovf_mask;

  alu_op_decode u_decode (
    .op       (in_op),
    .add_sub  (dec_add_sub),
    .logic_fn (dec_logic_fn),
    .fn_class (dec_fn_class),
    .illegal  (dec_illegal),
    .ovf_mask (dec_ovf_mask)
  );

  // Issue FSM with the latency down-counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      illegal_q    <= 1'b0;
      ovf_en       <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_add_sub  <= 1'b0;
      alu_logic_fn <= '0;
      alu_fn_class <= '0;
      out_result   <= '0;
      out_ovf      <= 1'b0;
      out_illegal  <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      ovf_trap     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_x        <= in_x;
            alu_y        <= in_y;
            alu_add_sub  <= dec_add_sub;
            alu_logic_fn <= dec_logic_fn;
            alu_fn_class <= dec_fn_class;
            illegal_q    <= dec_illegal;
            ovf_en       <= dec_ovf_mask;
            cnt          <= LAT_LOAD;
            in_ready     <= 1'b0;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            out_result  <= illegal_q ? '0 : alu_result;
            out_ovf     <= alu_overflow & ovf_en;
            out_illegal <= illegal_q;
            out_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
            if (out_ovf) begin
              ovf_trap <= 1'b1;
              state    <= ST_TRAP;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end
`else
            in_ready <= 1'b1;
            state    <= ST_IDLE;
`endif
          end
        end
        ST_TRAP: begin
`ifdef ALU_OVF_TRAP_EN
          if (trap_clr) begin
            ovf_trap <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
`else
          in_ready <= 1'b1;
          state    <= ST_IDLE;
`endif
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
